// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma block copy/fill engine.
package mem_dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [3:0]  WSTRB_READ = 4'b0000;
  localparam logic [3:0]  WSTRB_WORD = 4'b1111;

endpackage

// File: rtl/mem_dma_if.sv
// Command, status and memory-bus signals of mem_dma.
// master: the DMA engine's view. slave: the firmware/responder side.
interface mem_dma_if #(
  parameter int unsigned LEN_BITS = 8
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [31:0]         cmd_src;
  logic [31:0]         cmd_dst;
  logic [LEN_BITS-1:0] cmd_len;
  logic                cmd_fill;
  logic [31:0]         cmd_pattern;
  logic                abort;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [LEN_BITS-1:0] words_done;
  logic                mem_valid;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wdata;
  logic [3:0]          mem_wstrb;
  logic [31:0]         mem_rdata;
  logic                mem_ready;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_pattern, abort,
    input  mem_rdata, mem_ready,
    output cmd_ready, busy, done, aborted, words_done,
    output mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_fill, cmd_pattern, abort,
    output mem_rdata, mem_ready,
    input  cmd_ready, busy, done, aborted, words_done,
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/mem_dma.sv
// mem_dma: bus-master block copy engine (READ word, WRITE word, repeat).
// Optional fill mode (write a constant pattern, no reads) is built only when
// MEM_DMA_FILL_EN is defined; otherwise every command is a copy.
// All outputs decode from registers only; nothing depends on mem_ready.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned LEN_BITS = 8
) (
  input logic        clk,
  input logic        resetn,
  mem_dma_if.master  io_bus
);

  state_e              r_state, w_state_next;
  logic [31:0]         r_src, r_dst, r_wdata;
  logic [LEN_BITS-1:0] r_len, r_words;
  logic                r_abort_pend, r_aborted;

  logic                w_busy, w_accept, w_hs, w_abort_now, w_last, w_fill;
  logic [LEN_BITS-1:0] w_words_inc;

`ifdef MEM_DMA_FILL_EN
  logic r_fill;
  assign w_fill = io_bus.cmd_fill;
`else
  logic w_unused_fill;
  assign w_fill        = 1'b0;
  assign w_unused_fill = ^{io_bus.cmd_fill, io_bus.cmd_pattern};
`endif

  assign w_busy      = (r_state == StRead) || (r_state == StWrite);
  assign w_accept    = (r_state == StIdle) && io_bus.cmd_valid;
  assign w_hs        = w_busy && io_bus.mem_ready;
  // An abort seen in the handshake cycle itself counts as well as a latched one.
  assign w_abort_now = io_bus.abort || r_abort_pend;
  assign w_words_inc = r_words + {{(LEN_BITS-1){1'b0}}, 1'b1};
  assign w_last      = (w_words_inc == r_len);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  // Next-state decode; bus transactions only leave a state on handshake.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (io_bus.cmd_valid) begin
          if (io_bus.cmd_len == '0) w_state_next = StDone;
          else if (w_fill)          w_state_next = StWrite;
          else                      w_state_next = StRead;
        end
      end
      StRead: begin
        if (w_hs) w_state_next = w_abort_now ? StDone : StWrite;
      end
      StWrite: begin
        if (w_hs) begin
          if (w_last || w_abort_now) w_state_next = StDone;
`ifdef MEM_DMA_FILL_EN
          else                       w_state_next = r_fill ? StWrite : StRead;
`else
          else                       w_state_next = StRead;
`endif
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    io_bus.cmd_ready  = (r_state == StIdle);
    io_bus.busy       = w_busy;
    io_bus.done       = (r_state == StDone);
    io_bus.aborted    = (r_state == StDone) && r_aborted;
    io_bus.words_done = r_words;
    io_bus.mem_valid  = w_busy;
    io_bus.mem_addr   = (r_state == StWrite) ? r_dst : r_src;
    io_bus.mem_wdata  = r_wdata;
    io_bus.mem_wstrb  = (r_state == StWrite) ? WSTRB_WORD : WSTRB_READ;
  end

  // Datapath: address pointers, data word, word counter and abort tracking.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_src        <= '0;
      r_dst        <= '0;
      r_wdata      <= '0;
      r_len        <= '0;
      r_words      <= '0;
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
`ifdef MEM_DMA_FILL_EN
      r_fill       <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_src        <= {io_bus.cmd_src[31:2], 2'b00};
        r_dst        <= {io_bus.cmd_dst[31:2], 2'b00};
        r_len        <= io_bus.cmd_len;
        r_words      <= '0;
        r_abort_pend <= 1'b0;
        r_aborted    <= 1'b0;
`ifdef MEM_DMA_FILL_EN
        r_fill       <= io_bus.cmd_fill;
        // The data register doubles as the pattern register in fill mode.
        if (io_bus.cmd_fill) r_wdata <= io_bus.cmd_pattern;
`endif
      end
      if (w_busy && io_bus.abort) r_abort_pend <= 1'b1;
      if ((r_state == StRead) && w_hs) begin
        r_wdata <= io_bus.mem_rdata;
        r_src   <= r_src + 32'(WORD_BYTES);
        if (w_abort_now) r_aborted <= 1'b1;
      end
      if ((r_state == StWrite) && w_hs) begin
        r_dst   <= r_dst + 32'(WORD_BYTES);
        r_words <= w_words_inc;
        if (w_abort_now) r_aborted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: behavioural memory responder with optional
// random stalls, a bus monitor that scores reads/writes against queues of
// expected transactions, and one task per scenario.
module tb_mem_dma;

  localparam int unsigned LB = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    int          done_cyc;
    logic        rdy_acc;
    logic        rdy_done;
    logic        busy_done;
    logic        aborted;
    logic [LB-1:0] words;
    logic        rdy_after;
  } res_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mem_dma_if #(.LEN_BITS(LB)) bus ();

  mem_dma #(.LEN_BITS(LB)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .io_bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [logic [29:0]];
  txn_t        wr_exp_q[$];
  logic [31:0] rd_exp_q[$];
  bit          sb_en    = 1'b1;
  bit          stall_en = 1'b0;
  int          stab_err  = 0;
  int          valid_cyc = 0;

  // Responder: picks the wait count per transaction and presents read data.
  logic prev_valid = 1'b0;
  int   wait_left  = 0;
  always @(negedge clk) begin
    if (bus.mem_valid) begin
      if (!(prev_valid && !bus.mem_ready)) wait_left = stall_en ? int'($urandom_range(0, 3)) : 0;
      else if (wait_left > 0)              wait_left--;
      bus.mem_ready = (wait_left == 0);
    end else begin
      bus.mem_ready = 1'b0;
    end
    bus.mem_rdata = mem.exists(bus.mem_addr[31:2]) ? mem[bus.mem_addr[31:2]] : 32'h0;
    prev_valid    = bus.mem_valid;
  end

  // Monitor: bus stability during stalls and scoreboard of completed transactions.
  logic        hold_pend = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_wstrb;
  always @(posedge clk) begin
    txn_t t, e;
    if (hold_pend && (!bus.mem_valid || bus.mem_addr !== h_addr || bus.mem_wdata !== h_wdata
                      || bus.mem_wstrb !== h_wstrb)) stab_err++;
    if (bus.mem_valid) valid_cyc++;
    if (bus.mem_valid && bus.mem_ready) begin
      hold_pend = 1'b0;
      if (sb_en && bus.mem_wstrb == 4'b1111) begin
        t = '{addr: bus.mem_addr, data: bus.mem_wdata};
        checks++;
        if (wr_exp_q.size() == 0) begin
          failures++;
          $display("FAIL wr_extra got addr=%h data=%h exp none", t.addr, t.data);
        end else begin
          e = wr_exp_q.pop_front();
          if (t !== e) begin
            failures++;
            $display("FAIL wr_txn got addr=%h data=%h exp addr=%h data=%h",
                     t.addr, t.data, e.addr, e.data);
          end
        end
      end else if (sb_en) begin
        checks++;
        if (rd_exp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_extra got addr=%h strb=%b exp none", bus.mem_addr, bus.mem_wstrb);
        end else begin
          e.addr = rd_exp_q.pop_front();
          if (bus.mem_addr !== e.addr || bus.mem_wstrb !== 4'b0000) begin
            failures++;
            $display("FAIL rd_txn got addr=%h strb=%b exp addr=%h strb=0000",
                     bus.mem_addr, bus.mem_wstrb, e.addr);
          end
        end
      end
    end else if (bus.mem_valid) begin
      hold_pend = 1'b1;
      h_addr    = bus.mem_addr;
      h_wdata   = bus.mem_wdata;
      h_wstrb   = bus.mem_wstrb;
    end else begin
      hold_pend = 1'b0;
    end
  end

  // Issue one command and follow it to completion (bounded); abort raised in cycle abort_cyc.
  task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [LB-1:0] len,
                         input logic fill, input logic [31:0] pat, input int abort_cyc,
                         output res_t r);
    @(negedge clk);
    r.rdy_acc       = bus.cmd_ready;
    bus.cmd_valid   = 1'b1;
    bus.cmd_src     = src;
    bus.cmd_dst     = dst;
    bus.cmd_len     = len;
    bus.cmd_fill    = fill;
    bus.cmd_pattern = pat;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    r.done_cyc = -1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      bus.abort = (n == abort_cyc);
      if (bus.done) begin
        r.done_cyc  = n;
        r.rdy_done  = bus.cmd_ready;
        r.busy_done = bus.busy;
        r.aborted   = bus.aborted;
        break;
      end
    end
    bus.abort = 1'b0;
    @(negedge clk);
    r.rdy_after = bus.cmd_ready;
    r.words     = bus.words_done;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.cmd_fill  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 9;
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    if (bus.aborted !== 1'b0) begin failures++; $display("FAIL rst_aborted got=%b exp=0", bus.aborted); end
    if (bus.words_done !== '0) begin failures++; $display("FAIL rst_words got=%0d exp=0", bus.words_done); end
    if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.mem_valid); end
    if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); end
    if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", bus.mem_wdata); end
    if (bus.mem_wstrb !== 4'b0) begin failures++; $display("FAIL rst_wstrb got=%b exp=0", bus.mem_wstrb); end
    resetn = 1'b1;
  endtask

  // Source words 0x000..0x00C preloaded; queue the reads and writes of a copy to dst.
  task automatic push_copy(input logic [31:0] dst, input int n);
    for (int i = 0; i < n; i++) begin
      rd_exp_q.push_back(32'(4 * i));
      wr_exp_q.push_back('{addr: dst + 32'(4 * i), data: 32'h11111111 * 32'(i + 1)});
    end
  endtask

  task automatic test_copy();
    res_t r;
    push_copy(32'h100, 4);
    run_cmd(32'h000, 32'h100, 8'd4, 1'b0, 32'h0, 0, r);
    checks += 8;
    if (r.rdy_acc !== 1'b1) begin failures++; $display("FAIL copy_rdy_acc got=%b exp=1", r.rdy_acc); end
    if (r.done_cyc !== 9) begin failures++; $display("FAIL copy_done_cyc got=%0d exp=9", r.done_cyc); end
    if (r.rdy_done !== 1'b0 || r.busy_done !== 1'b0) begin
      failures++; $display("FAIL copy_done_flags got rdy=%b busy=%b exp 0 0", r.rdy_done, r.busy_done);
    end
    if (r.aborted !== 1'b0) begin failures++; $display("FAIL copy_aborted got=%b exp=0", r.aborted); end
    if (r.words !== 8'd4) begin failures++; $display("FAIL copy_words got=%0d exp=4", r.words); end
    if (r.rdy_after !== 1'b1) begin failures++; $display("FAIL copy_rdy_after got=%b exp=1", r.rdy_after); end
    if (wr_exp_q.size() != 0) begin failures++; $display("FAIL copy_wr_left got=%0d exp=0", wr_exp_q.size()); end
    if (rd_exp_q.size() != 0) begin failures++; $display("FAIL copy_rd_left got=%0d exp=0", rd_exp_q.size()); end
  endtask

  task automatic test_stall();
    res_t r;
    int   s0 = stab_err;
    stall_en = 1'b1;
    push_copy(32'h180, 4);
    run_cmd(32'h000, 32'h180, 8'd4, 1'b0, 32'h0, 0, r);
    stall_en = 1'b0;
    checks += 4;
    if (r.done_cyc < 9) begin failures++; $display("FAIL stall_done_cyc got=%0d exp>=9", r.done_cyc); end
    if (stab_err != s0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stab_err - s0); end
    if (r.words !== 8'd4) begin failures++; $display("FAIL stall_words got=%0d exp=4", r.words); end
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      failures++; $display("FAIL stall_left got wr=%0d rd=%0d exp 0 0", wr_exp_q.size(), rd_exp_q.size());
    end
  endtask

  task automatic test_len0();
    res_t r;
    int   v0 = valid_cyc;
    run_cmd(32'h000, 32'h200, 8'd0, 1'b0, 32'h0, 0, r);
    checks += 3;
    if (r.done_cyc !== 1) begin failures++; $display("FAIL len0_done_cyc got=%0d exp=1", r.done_cyc); end
    if (valid_cyc != v0) begin failures++; $display("FAIL len0_valid got=%0d exp=0", valid_cyc - v0); end
    if (r.words !== 8'd0) begin failures++; $display("FAIL len0_words got=%0d exp=0", r.words); end
  endtask

  task automatic test_abort();
    res_t r;
    rd_exp_q.push_back(32'h0);
    rd_exp_q.push_back(32'h4);
    wr_exp_q.push_back('{addr: 32'h300, data: 32'h11111111});
    run_cmd(32'h000, 32'h300, 8'd8, 1'b0, 32'h0, 3, r);
    checks += 4;
    if (r.done_cyc !== 4) begin failures++; $display("FAIL abort_done_cyc got=%0d exp=4", r.done_cyc); end
    if (r.aborted !== 1'b1) begin failures++; $display("FAIL abort_flag got=%b exp=1", r.aborted); end
    if (r.words !== 8'd1) begin failures++; $display("FAIL abort_words got=%0d exp=1", r.words); end
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      failures++; $display("FAIL abort_left got wr=%0d rd=%0d exp 0 0", wr_exp_q.size(), rd_exp_q.size());
    end
  endtask

  task automatic test_wrap();
    res_t r;
    mem[30'h3FFFFFFF] = 32'hA5A5A5A5;
    rd_exp_q.push_back(32'hFFFFFFFC);
    rd_exp_q.push_back(32'h00000000);
    wr_exp_q.push_back('{addr: 32'h400, data: 32'hA5A5A5A5});
    wr_exp_q.push_back('{addr: 32'h404, data: 32'h11111111});
    run_cmd(32'hFFFFFFFC, 32'h400, 8'd2, 1'b0, 32'h0, 0, r);
    checks += 2;
    if (r.done_cyc !== 5) begin failures++; $display("FAIL wrap_done_cyc got=%0d exp=5", r.done_cyc); end
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      failures++; $display("FAIL wrap_left got wr=%0d rd=%0d exp 0 0", wr_exp_q.size(), rd_exp_q.size());
    end
    // Abort while idle must not leak into the next transfer.
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    rd_exp_q.push_back(32'h000);
    wr_exp_q.push_back('{addr: 32'h500, data: 32'h11111111});
    run_cmd(32'h003, 32'h502, 8'd1, 1'b0, 32'h0, 0, r);
    checks += 3;
    if (r.done_cyc !== 3) begin failures++; $display("FAIL unalign_done_cyc got=%0d exp=3", r.done_cyc); end
    if (r.aborted !== 1'b0) begin failures++; $display("FAIL idle_abort got=%b exp=0", r.aborted); end
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      failures++; $display("FAIL unalign_left got wr=%0d rd=%0d exp 0 0", wr_exp_q.size(), rd_exp_q.size());
    end
  endtask

  task automatic test_fill();
    res_t r;
    int   exp_cyc;
`ifdef MEM_DMA_FILL_EN
    for (int i = 0; i < 3; i++) wr_exp_q.push_back('{addr: 32'h40 + 32'(4 * i), data: 32'hDEADBEEF});
    exp_cyc = 4;
`else
    push_copy(32'h40, 3);
    exp_cyc = 7;
`endif
    run_cmd(32'h000, 32'h040, 8'd3, 1'b1, 32'hDEADBEEF, 0, r);
    checks += 3;
    if (r.done_cyc !== exp_cyc) begin
      failures++; $display("FAIL fill_done_cyc got=%0d exp=%0d", r.done_cyc, exp_cyc);
    end
    if (r.words !== 8'd3) begin failures++; $display("FAIL fill_words got=%0d exp=3", r.words); end
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      failures++; $display("FAIL fill_left got wr=%0d rd=%0d exp 0 0", wr_exp_q.size(), rd_exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    sb_en = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = 32'h0;
    bus.cmd_dst   = 32'h600;
    bus.cmd_len   = 8'd8;
    bus.cmd_fill  = 1'b0;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks += 4;
    if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", bus.mem_valid); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
    if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", bus.cmd_ready); end
    if (bus.words_done !== '0) begin failures++; $display("FAIL rmid_words got=%0d exp=0", bus.words_done); end
    resetn = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[30'(i)] = 32'h11111111 * 32'(i + 1);
    test_reset();
    test_copy();
    test_stall();
    test_len0();
    test_abort();
    test_wrap();
    test_fill();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_dma.md
# mem_dma

Bus-initiator block copy/fill engine for the SoC's 32-bit valid/ready memory bus. It accepts a command (source, destination, word count), then drives word-wide read and write transactions as a bus master against any valid/ready responder, such as the FRAM or SRAM. Firmware uses it to move key material and hash state between memories and, optionally, to zeroize regions, without occupying the CPU.

## Interface
Parameters:
- LEN_BITS, 8, width of word-count field; maximum transfer is 2^LEN_BITS-1 words

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE; command accepted on cmd_valid && cmd_ready
- cmd_src  in  32  source byte address; bits [1:0] ignored
- cmd_dst  in  32  destination byte address; bits [1:0] ignored
- cmd_len  in  LEN_BITS  number of 32-bit words
- cmd_fill  in  1  fill mode select (see Configuration)
- cmd_pattern  in  32  fill word
- abort  in  1  request early termination
- busy  out  1  high from acceptance until DONE
- done  out  1  one-cycle completion pulse
- aborted  out  1  valid with done; transfer ended by abort
- words_done  out  LEN_BITS  words written so far; holds after done until the next accept
- mem_valid  out  1  bus request
- mem_addr  out  32  bus byte address, always word-aligned
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'b0000 for read, 4'b1111 for write
- mem_rdata  in  32  read data, sampled on handshake
- mem_ready  in  1  responder ready; may be combinational from mem_valid

## Operation
- States: IDLE, READ, WRITE, DONE. All outputs are registered; no output depends combinationally on mem_ready.
- IDLE: on accept, latch src and dst with bits [1:0] forced to 0, latch len and pattern, and clear words_done.
  - len==0 goes to DONE.
  - Fill mode goes to WRITE.
  - Otherwise the block goes to READ.
- READ: mem_valid=1, mem_addr=src, mem_wstrb=0.
  - On handshake (mem_valid && mem_ready), capture mem_rdata into mem_wdata, src+=4, go WRITE.
- WRITE: mem_valid=1, mem_addr=dst, mem_wstrb=4'b1111.
  - On handshake, dst+=4 and words_done+=1.
  - If words_done+1==len, go DONE.
  - Otherwise go READ for copy, or stay in WRITE for fill.
- DONE: done=1, busy=0, cmd_ready=0 for exactly one cycle, then IDLE.
- Bus rule: once mem_valid is raised, mem_addr, mem_wdata and mem_wstrb are held stable until handshake. mem_valid may stay high back-to-back across consecutive transactions.
- Addresses increment modulo 2^32; wrap past 0xFFFFFFFC goes to 0x00000000 silently.
- Copy is ascending only. An overlapping region with dst > src propagates the source data forward; this is documented, not corrected.
- abort:
  - Sampled every cycle while busy. A pending abort is latched.
  - The in-flight bus transaction always completes; mem_valid never drops before its handshake.
  - After that handshake the block goes to DONE with aborted=1. An abort during READ still completes the read and goes straight to DONE without the write.
  - Abort in IDLE or DONE is ignored.
- cmd_valid while not in IDLE is ignored (cmd_ready=0).

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, aborted=0, words_done=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
- Reset asserted mid-transfer wins over the bus rule: at the next edge all outputs take their reset values and the state returns to IDLE.
- The accept edge is cycle 0. mem_valid rises in cycle 1.
- Zero-wait responder, copy of N words:
  - Bus busy cycles 1..2N.
  - done high in cycle 2N+1.
  - cmd_ready high in cycle 2N+2.
- Fill of N words with a zero-wait responder: writes in cycles 1..N, done in cycle N+1.
- len==0: done in cycle 1, with no bus activity.
- Each responder wait cycle adds one cycle.

## Configuration
- MEM_DMA_FILL_EN defined: cmd_fill=1 selects fill mode, which writes cmd_pattern to len words at dst with no reads.
- MEM_DMA_FILL_EN undefined:
  - cmd_fill and cmd_pattern are ignored, and all commands are copies.
  - The pattern register and the WRITE->WRITE transition are not built.

## Structure
- Package mem_dma_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE)
  - WORD_BYTES=4
  - WSTRB_READ=4'b0000
  - WSTRB_WORD=4'b1111
- No sub-module is warranted. The FSM, address registers and word counter are a single module.

## Test plan
- Copy with a 10-bit-address FRAM as responder, preloaded 0x11111111..0x44444444 at 0x000..0x00C; command src=0x000, dst=0x100, len=4 -> FRAM 0x100..0x10C match; done in cycle 9; words_done=4; aborted=0.
- Random mem_ready stalls (0-3 cycles) on the same copy -> identical memory result; address, data and strobe stable throughout each stall; no extra writes.
- len=0 -> done in cycle 1; mem_valid never asserted.
- Abort raised during the 2nd READ of a len=8 copy -> the read completes, no 2nd write occurs, done=1 with aborted=1, words_done=1.
- src=0xFFFFFFFC, len=2, with a behavioural memory -> read addresses 0xFFFFFFFC then 0x00000000; cmd_src=0x003 -> first read address 0x000.
- MEM_DMA_FILL_EN: fill pattern=0xDEADBEEF, dst=0x040, len=3 -> three consecutive writes, done in cycle 4. Without the macro, the same command performs a copy from cmd_src.
